// File: rtl/fd_pkg.sv
// Shared types and constants for the mini-MIPS fetch/decode front end.
package fd_pkg;

  // Default datapath width.
  localparam int XLEN_DEFAULT = 32;

  // Instruction class reported on dec_type.
  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } dec_type_t;

  // Opcodes that select a non-I classification.
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;

  // Front-end control states: one fetch outstanding at a time.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_OUT   = 2'd2
  } fsm_state_t;

  // Map an opcode to its instruction class.
  function automatic dec_type_t classify_op(input logic [5:0] op);
    dec_type_t t;
    if (op == OP_RTYPE) begin
      t = TYPE_R;
    end else if ((op == OP_J) || (op == OP_JAL)) begin
      t = TYPE_J;
    end else begin
      t = TYPE_I;
    end
    return t;
  endfunction

endpackage

// File: rtl/fd_regfile.sv
// Register file: two combinational read ports with same-cycle write bypass,
// one synchronous write port, R0 hardwired to zero, cleared on reset.
module fd_regfile
  import fd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];

  assign w_raddr[0] = i_raddr_a;
  assign w_raddr[1] = i_raddr_b;
  assign o_rdata_a  = w_rdata[0];
  assign o_rdata_b  = w_rdata[1];

  // Write port: clear everything on reset, never store into R0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: R0 reads zero, a matching write in this cycle is forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign w_rdata[gi] = (w_raddr[gi] == '0)                 ? '0      :
                           (i_we && (i_waddr == w_raddr[gi]))  ? i_wdata :
                                                                 r_regs[w_raddr[gi]];
    end
  endgenerate

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: fetches one word at a time, classifies it,
// reads operands with write-back bypass and hands it to execute.
module fetch_decode_unit
  import fd_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             RA_W     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [1:0]      dec_type,
  output logic [5:0]      dec_opcode,
  output logic [5:0]      dec_func,
  output logic [4:0]      dec_rs,
  output logic [4:0]      dec_rt,
  output logic [4:0]      dec_rd,
  output logic [4:0]      dec_shamt,
  output logic [15:0]     dec_imm,
  output logic [XLEN-1:0] dec_imm_sext,
  output logic [25:0]     dec_addr,
  output logic [XLEN-1:0] dec_rs_val,
  output logic [XLEN-1:0] dec_rt_val
);

  fsm_state_t      r_state;
  fsm_state_t      w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_drop;
  logic            w_drop_next;
  // Holds the request line low for the first cycle after reset.
  logic            r_started;
  logic            w_req_fire;
  logic            w_load_dec;
  logic [31:0]     w_instr;

  logic [XLEN-1:0] r_dec_pc;
  dec_type_t       r_dec_type;
  logic [5:0]      r_dec_opcode;
  logic [5:0]      r_dec_func;
  logic [4:0]      r_dec_rs;
  logic [4:0]      r_dec_rt;
  logic [4:0]      r_dec_rd;
  logic [4:0]      r_dec_shamt;
  logic [15:0]     r_dec_imm;
  logic [XLEN-1:0] r_dec_imm_sext;
  logic [25:0]     r_dec_addr;

  assign w_instr        = imem_rsp_data;
  assign imem_req_valid = (r_state == ST_FETCH) && r_started;
  assign imem_req_addr  = imem_req_valid ? r_pc : '0;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign dec_valid      = (r_state == ST_OUT);

  assign dec_pc       = r_dec_pc;
  assign dec_type     = r_dec_type;
  assign dec_opcode   = r_dec_opcode;
  assign dec_func     = r_dec_func;
  assign dec_rs       = r_dec_rs;
  assign dec_rt       = r_dec_rt;
  assign dec_rd       = r_dec_rd;
  assign dec_shamt    = r_dec_shamt;
  assign dec_imm      = r_dec_imm;
  assign dec_imm_sext = r_dec_imm_sext;
  assign dec_addr     = r_dec_addr;

  // Control state, fetch PC and the drop-next-response flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_drop    <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_drop    <= w_drop_next;
      r_started <= 1'b1;
    end
  end

  // Next-state logic; a redirect overrides everything else.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_load_dec   = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (w_req_fire) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_drop) begin
            // Stale response from before a redirect: discard it.
            w_drop_next  = 1'b0;
            w_state_next = ST_FETCH;
          end else begin
            w_load_dec   = 1'b1;
            w_pc_next    = r_pc + XLEN'(4);
            w_state_next = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (dec_ready) begin
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase

    if (redirect_valid) begin
      w_pc_next  = redirect_pc;
      w_load_dec = 1'b0;
      case (r_state)
        ST_FETCH: begin
          // A request accepted this cycle still owes us a response.
          if (w_req_fire) begin
            w_state_next = ST_WAIT;
            w_drop_next  = 1'b1;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
        ST_WAIT: begin
          // If the response is here now it is simply not used; otherwise
          // wait for it with the drop flag so only one fetch is in flight.
          if (imem_rsp_valid) begin
            w_state_next = ST_FETCH;
            w_drop_next  = 1'b0;
          end else begin
            w_state_next = ST_WAIT;
            w_drop_next  = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_FETCH;
        end
      endcase
    end
  end

  // Decode register: capture all fields of an accepted response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_pc       <= '0;
      r_dec_type     <= TYPE_R;
      r_dec_opcode   <= '0;
      r_dec_func     <= '0;
      r_dec_rs       <= '0;
      r_dec_rt       <= '0;
      r_dec_rd       <= '0;
      r_dec_shamt    <= '0;
      r_dec_imm      <= '0;
      r_dec_imm_sext <= '0;
      r_dec_addr     <= '0;
    end else if (w_load_dec) begin
      r_dec_pc       <= r_pc;
      r_dec_type     <= classify_op(w_instr[31:26]);
      r_dec_opcode   <= w_instr[31:26];
      r_dec_func     <= w_instr[5:0];
      r_dec_rs       <= w_instr[25:21];
      r_dec_rt       <= w_instr[20:16];
      r_dec_rd       <= w_instr[15:11];
      r_dec_shamt    <= w_instr[10:6];
      r_dec_imm      <= w_instr[15:0];
      r_dec_imm_sext <= {{(XLEN-16){w_instr[15]}}, w_instr[15:0]};
      r_dec_addr     <= w_instr[25:0];
    end
  end

  // Operands come straight from the register file at the held indices.
  fd_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (RA_W)
  ) u_regfile (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (r_dec_rs[RA_W-1:0]),
    .i_raddr_b (r_dec_rt[RA_W-1:0]),
    .o_rdata_a (dec_rs_val),
    .o_rdata_b (dec_rt_val)
  );

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit with a decode scoreboard.
module tb_fetch_decode_unit;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RA_W  = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            wb_en = 1'b0;
  logic [RA_W-1:0] wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            dec_valid;
  logic            dec_ready = 1'b0;
  logic [XLEN-1:0] dec_pc;
  logic [1:0]      dec_type;
  logic [5:0]      dec_opcode;
  logic [5:0]      dec_func;
  logic [4:0]      dec_rs;
  logic [4:0]      dec_rt;
  logic [4:0]      dec_rd;
  logic [4:0]      dec_shamt;
  logic [15:0]     dec_imm;
  logic [XLEN-1:0] dec_imm_sext;
  logic [25:0]     dec_addr;
  logic [XLEN-1:0] dec_rs_val;
  logic [XLEN-1:0] dec_rt_val;

  always #5 clk = ~clk;

  fetch_decode_unit #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .RESET_PC ('0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_type       (dec_type),
    .dec_opcode     (dec_opcode),
    .dec_func       (dec_func),
    .dec_rs         (dec_rs),
    .dec_rt         (dec_rt),
    .dec_rd         (dec_rd),
    .dec_shamt      (dec_shamt),
    .dec_imm        (dec_imm),
    .dec_imm_sext   (dec_imm_sext),
    .dec_addr       (dec_addr),
    .dec_rs_val     (dec_rs_val),
    .dec_rt_val     (dec_rt_val)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [25:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_regs [NREGS];
  int          n_total = 0;
  int          n_bad = 0;

  // Reference register contents, updated from the write-back inputs.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) model_regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      model_regs[wb_addr] <= wb_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t make_exp(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.pc       = pc;
    e.opcode   = w[31:26];
    if (w[31:26] == 6'd0)                            e.typ = 2'd0;
    else if ((w[31:26] == 6'd2) || (w[31:26] == 6'd3)) e.typ = 2'd2;
    else                                             e.typ = 2'd1;
    e.func     = w[5:0];
    e.rs       = w[25:21];
    e.rt       = w[20:16];
    e.rd       = w[15:11];
    e.shamt    = w[10:6];
    e.imm      = w[15:0];
    e.imm_sext = {{16{w[15]}}, w[15:0]};
    e.addr     = w[25:0];
    return e;
  endfunction

  function automatic logic [31:0] op_exp(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (wb_en && (wb_addr == idx)) return wb_data;
    return model_regs[idx];
  endfunction

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n = 0;
    while (!imem_req_valid && (n < 50)) begin
      step();
      n++;
    end
    chk({tag, "_req_valid"}, imem_req_valid, 1);
    chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
  endtask

  task automatic accept();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
  endtask

  // Respond with a word and queue the decode we expect for it.
  task automatic push_rsp(input logic [31:0] w, input logic [31:0] pc);
    sb_q.push_back(make_exp(w, pc));
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  // Compare the presented decode with the scoreboard head, then transfer it.
  task automatic finish_dec(input string tag);
    exp_t e;
    chk({tag, "_dec_valid"}, dec_valid, 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"},       dec_pc,       e.pc);
      chk({tag, "_type"},     dec_type,     e.typ);
      chk({tag, "_opcode"},   dec_opcode,   e.opcode);
      chk({tag, "_func"},     dec_func,     e.func);
      chk({tag, "_rs"},       dec_rs,       e.rs);
      chk({tag, "_rt"},       dec_rt,       e.rt);
      chk({tag, "_rd"},       dec_rd,       e.rd);
      chk({tag, "_shamt"},    dec_shamt,    e.shamt);
      chk({tag, "_imm"},      dec_imm,      e.imm);
      chk({tag, "_imm_sext"}, dec_imm_sext, e.imm_sext);
      chk({tag, "_addr"},     dec_addr,     e.addr);
      chk({tag, "_rs_val"},   dec_rs_val,   op_exp(e.rs));
      chk({tag, "_rt_val"},   dec_rt_val,   op_exp(e.rt));
    end
    $display("txn %s: pc=0x%0h type=%0d rs=%0d rt=%0d", tag, dec_pc, dec_type, dec_rs, dec_rt);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk({tag, "_valid_drop"}, dec_valid, 0);
    chk({tag, "_refetch"}, imem_req_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset: everything quiet.
    repeat (3) step();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_imm_sext", dec_imm_sext, 0);
    chk("rst_rs_val", dec_rs_val, 0);
    reset = 1'b0;
    chk("rst_release_req", imem_req_valid, 0);
    step();
    chk("req_rise", imem_req_valid, 1);

    // Preload R9 and R10 while the request is held off.
    wb_en = 1'b1; wb_addr = 5'd9;  wb_data = 32'h1111; step();
    wb_addr = 5'd10; wb_data = 32'h2222; step();
    wb_en = 1'b0;

    // add $8,$9,$10
    wait_req(32'h0, "add");
    accept();
    push_rsp(32'h012A4020, 32'h0);
    chk("add_latency", dec_valid, 1);
    chk("add_type_r", dec_type, 0);
    finish_dec("add");

    // addi with negative immediate
    wait_req(32'h4, "addi");
    accept();
    push_rsp(32'h2128FFFF, 32'h4);
    chk("addi_sext", dec_imm_sext, 32'hFFFFFFFF);
    chk("addi_type_i", dec_type, 1);
    finish_dec("addi");

    // jal, with execute stalling for 5 cycles
    wait_req(32'h8, "jal");
    accept();
    push_rsp(32'h0C000010, 32'h8);
    chk("jal_type_j", dec_type, 2);
    chk("jal_addr", dec_addr, 26'h10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", dec_valid, 1);
      chk("stall_pc", dec_pc, 32'h8);
      chk("stall_addr", dec_addr, 26'h10);
      chk("stall_no_req", imem_req_valid, 0);
    end
    finish_dec("jal");

    // Write-back bypass onto the operand outputs, and R0 write ignored.
    wait_req(32'hC, "byp");
    accept();
    push_rsp(32'h01200020, 32'hC);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    #1;
    chk("byp_same_cycle", dec_rs_val, 32'h55);
    step();
    wb_addr = 5'd0; wb_data = 32'hDEAD;
    #1;
    chk("byp_array", dec_rs_val, 32'h55);
    chk("r0_write_bypass", dec_rt_val, 0);
    step();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    chk("r0_write_array", dec_rt_val, 0);
    finish_dec("byp");

    // Redirect while in FETCH without acceptance.
    wait_req(32'h10, "rdf");
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("rdf_addr", imem_req_addr, 32'h200);

    // Redirect while in WAIT: the stale response must vanish.
    accept();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h012A4020;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    chk("stale_no_valid", dec_valid, 0);
    wait_req(32'h100, "rdw");
    chk("rdw_no_valid", dec_valid, 0);
    accept();
    push_rsp(32'h8D2A0004, 32'h100);
    finish_dec("lw");

    // Reset during WAIT, then a late response.
    wait_req(32'h104, "rstw");
    accept();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_req_low", imem_req_valid, 0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2128FFFF;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    chk("late_rsp_valid", dec_valid, 0);
    chk("late_rsp_pc", dec_pc, 0);
    chk("late_rsp_type", dec_type, 0);
    chk("late_rsp_rs", dec_rs, 0);
    wait_req(32'h0, "post_rst");
    accept();
    push_rsp(32'h012A4020, 32'h0);
    chk("post_rst_cleared_rs", dec_rs_val, 0);
    finish_dec("post_rst");

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
